// File: rtl/axis_pkg.sv
// rtl/axis_pkg.sv - shared types and helpers for AXI-Stream arbitration blocks
package axis_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  localparam int AXIS_DATA_WIDTH_DFLT = 64;
  localparam int STRB_W = AXIS_DATA_WIDTH_DFLT / 8;

  // Index width for a port count; a single port still needs one bit.
  function automatic int grant_w(input int ports_nr);
    return (ports_nr > 1) ? $clog2(ports_nr) : 1;
  endfunction

endpackage

// File: rtl/rr_select.sv
// rtl/rr_select.sv - combinational rotate-priority encoder
// Picks the first set request after 'last', wrapping modulo PORTS_NR.
module rr_select #(
  parameter int PORTS_NR = 4,
  parameter int GRANT_W  = 2
) (
  input  logic [PORTS_NR-1:0] req,
  input  logic [GRANT_W-1:0]  last,
  output logic [GRANT_W-1:0]  grant,
  output logic                any
);

  int              idx;
  logic [GRANT_W-1:0] idx_w;

  always_comb begin
    grant = '0;
    any   = 1'b0;
    idx   = 0;
    idx_w = '0;
    for (int i = 1; i <= PORTS_NR; i++) begin
      idx   = (int'(last) + i) % PORTS_NR;
      idx_w = GRANT_W'(idx);
      if (!any && req[idx_w]) begin
        any   = 1'b1;
        grant = idx_w;
      end
    end
  end

endmodule

// File: rtl/axis_rr_arbiter.sv
// rtl/axis_rr_arbiter.sv - N:1 AXI-Stream round-robin arbiter with packet locking
// Define AXIS_ARB_STATUS_EN to add grant_o, busy_o and per-port packet counters.
module axis_rr_arbiter
  import axis_pkg::*;
#(
  parameter int AXIS_DATA_WIDTH = 64,
  parameter int PORTS_NR        = 4
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic [PORTS_NR-1:0]                   s_axis_tvalid,
  input  logic [PORTS_NR*AXIS_DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [PORTS_NR*AXIS_DATA_WIDTH/8-1:0] s_axis_tstrb,
  input  logic [PORTS_NR-1:0]                   s_axis_tlast,
  output logic [PORTS_NR-1:0]                   s_axis_tready,
  output logic                                  m_axis_tvalid,
  output logic [AXIS_DATA_WIDTH-1:0]            m_axis_tdata,
  output logic [AXIS_DATA_WIDTH/8-1:0]          m_axis_tstrb,
  output logic                                  m_axis_tlast,
  input  logic                                  m_axis_tready
`ifdef AXIS_ARB_STATUS_EN
  ,
  output logic [grant_w(PORTS_NR)-1:0]          grant_o,
  output logic                                  busy_o,
  output logic [PORTS_NR*16-1:0]                pkt_cnt_o
`endif
);

  localparam int GW         = grant_w(PORTS_NR);
  localparam int STRB_WIDTH = AXIS_DATA_WIDTH / 8;

  arb_state_t           state, state_nxt;
  logic [GW-1:0]        grant, grant_nxt;
  logic [GW-1:0]        last, last_nxt;
  logic [GW-1:0]        rr_grant;
  logic                 rr_any;
  logic                 sel_valid, sel_last, sel_ready, accept;
  logic [AXIS_DATA_WIDTH-1:0] sel_data;
  logic [STRB_WIDTH-1:0]      sel_strb;

  rr_select #(
    .PORTS_NR (PORTS_NR),
    .GRANT_W  (GW)
  ) u_rr_select (
    .req   (s_axis_tvalid),
    .last  (last),
    .grant (rr_grant),
    .any   (rr_any)
  );

  // Only the granted port is ever looked at; the rest may carry anything.
  assign sel_valid = s_axis_tvalid[grant];
  assign sel_last  = s_axis_tlast[grant];
  assign sel_data  = s_axis_tdata[grant*AXIS_DATA_WIDTH +: AXIS_DATA_WIDTH];
  assign sel_strb  = s_axis_tstrb[grant*STRB_WIDTH +: STRB_WIDTH];
  assign sel_ready = (state == BUSY) && (!m_axis_tvalid || m_axis_tready);
  assign accept    = sel_ready && sel_valid;

  always_comb begin
    s_axis_tready        = '0;
    s_axis_tready[grant] = sel_ready;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
      grant <= '0;
      last  <= GW'(PORTS_NR - 1);
    end else begin
      state <= state_nxt;
      grant <= grant_nxt;
      last  <= last_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    last_nxt  = last;
    case (state)
      IDLE: begin
        if (rr_any) begin
          grant_nxt = rr_grant;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (accept && sel_last) begin
          last_nxt  = grant;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tstrb  <= '0;
      m_axis_tlast  <= 1'b0;
    end else if (accept) begin
      m_axis_tvalid <= 1'b1;
      m_axis_tdata  <= sel_data;
      m_axis_tstrb  <= sel_strb;
      m_axis_tlast  <= sel_last;
    end else if (m_axis_tready) begin
      m_axis_tvalid <= 1'b0;
    end
  end

`ifdef AXIS_ARB_STATUS_EN
  logic [15:0] pkt_cnt [PORTS_NR];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < PORTS_NR; i++) pkt_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < PORTS_NR; i++) begin
        if (accept && sel_last && (grant == GW'(i))) pkt_cnt[i] <= pkt_cnt[i] + 16'd1;
      end
    end
  end

  for (genvar g = 0; g < PORTS_NR; g++) begin : g_cnt
    assign pkt_cnt_o[g*16 +: 16] = pkt_cnt[g];
  end

  assign grant_o = grant;
  assign busy_o  = (state == BUSY);
`endif

endmodule
